// File: rtl/ps2k_rx.sv
// rtl/ps2k_rx.sv - PS/2 keyboard receiver: synchronizer, clock filter, frame FSM, E0/F0 prefix decode, event storage.
// Define PS2K_RX_FIFO_EN for a 4-entry event FIFO; otherwise a single holding register is used.
module ps2k_rx #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2kCk,
    input  logic       ps2kD,
    output logic [7:0] code,
    output logic       ext,
    output logic       rel,
    output logic       valid,
    input  logic       ack,
    output logic       ovf,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frameState;

    logic        ckS1, ckS2, dS1, dS2;
    logic        ckFilt;
    logic [7:0]  filtCnt;
    logic        filtDone;
    logic        fall;
    frameState   state;
    logic [2:0]  bitCnt;
    logic [7:0]  shiftReg;
    logic        parOk;
    logic [15:0] toCnt;
    logic        extP, relP;
    logic        storeEv;
    logic [9:0]  evData;

    assign filtDone = (filtCnt == 8'(FILTER - 1));
    // A falling edge is the very cycle the filter commits its 1->0 change.
    assign fall     = ckFilt & ~ckS2 & filtDone;
    assign storeEv  = fall && (state == STOP) && dS2 && parOk
                      && (shiftReg != 8'hE0) && (shiftReg != 8'hF0);
    assign evData   = {extP, relP, shiftReg};

    always_ff @(posedge clock) begin
        if (reset) begin
            ckS1    <= 1'b1;
            ckS2    <= 1'b1;
            dS1     <= 1'b1;
            dS2     <= 1'b1;
            ckFilt  <= 1'b1;
            filtCnt <= 8'd0;
        end else begin
            ckS1 <= ps2kCk;
            ckS2 <= ckS1;
            dS1  <= ps2kD;
            dS2  <= dS1;
            if (ckS2 != ckFilt) begin
                if (filtDone) begin
                    ckFilt  <= ckS2;
                    filtCnt <= 8'd0;
                end else begin
                    filtCnt <= filtCnt + 8'd1;
                end
            end else begin
                filtCnt <= 8'd0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            bitCnt   <= 3'd0;
            shiftReg <= 8'd0;
            parOk    <= 1'b0;
            toCnt    <= 16'd0;
            extP     <= 1'b0;
            relP     <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            if (fall) begin
                case (state)
                    IDLE: begin
                        if (!dS2) begin
                            state  <= DATA;
                            bitCnt <= 3'd0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    DATA: begin
                        shiftReg <= {dS2, shiftReg[7:1]};
                        bitCnt   <= bitCnt + 3'd1;
                        if (bitCnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        parOk <= ^{dS2, shiftReg};
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (dS2 && parOk) begin
                            if (shiftReg == 8'hE0) begin
                                extP <= 1'b1;
                            end else if (shiftReg == 8'hF0) begin
                                relP <= 1'b1;
                            end else begin
                                extP <= 1'b0;
                                relP <= 1'b0;
                            end
                        end else begin
                            err  <= 1'b1;
                            extP <= 1'b0;
                            relP <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
            if (state == IDLE || fall) begin
                toCnt <= 16'd0;
            end else if (toCnt == 16'(TIMEOUT - 1)) begin
                toCnt <= 16'd0;
                state <= IDLE;
                err   <= 1'b1;
                extP  <= 1'b0;
                relP  <= 1'b0;
            end else begin
                toCnt <= toCnt + 16'd1;
            end
        end
    end

`ifdef PS2K_RX_FIFO_EN
    logic [9:0] fifoMem [4];
    logic [1:0] rdPtr, wrPtr;
    logic [2:0] count;
    logic       pop, push;

    assign pop   = ack && (count != 3'd0);
    // When full, a same-cycle pop frees the head slot that wrPtr points at.
    assign push  = storeEv && ((count != 3'd4) || pop);
    assign valid = (count != 3'd0);
    assign {ext, rel, code} = fifoMem[rdPtr];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) fifoMem[i] <= 10'd0;
            rdPtr <= 2'd0;
            wrPtr <= 2'd0;
            count <= 3'd0;
            ovf   <= 1'b0;
        end else begin
            ovf <= storeEv && !push;
            if (push) begin
                fifoMem[wrPtr] <= evData;
                wrPtr          <= wrPtr + 2'd1;
            end
            if (pop) rdPtr <= rdPtr + 2'd1;
            count <= count + 3'(push) - 3'(pop);
        end
    end
`else
    always_ff @(posedge clock) begin
        if (reset) begin
            code  <= 8'd0;
            ext   <= 1'b0;
            rel   <= 1'b0;
            valid <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            ovf <= 1'b0;
            if (storeEv && (!valid || ack)) begin
                {ext, rel, code} <= evData;
                valid            <= 1'b1;
            end else begin
                if (storeEv) ovf <= 1'b1;
                if (ack) valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ps2k_rx.sv
// tb/tb_ps2k_rx.sv - randomized frame stimulus for ps2k_rx checked against a queue-based event model.
module tb_ps2k_rx;
    localparam int FILTER  = 4;
    localparam int TIMEOUT = 300;
    localparam int HALF    = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ps2kCk = 1'b1;
    logic       ps2kD = 1'b1;
    logic [7:0] code;
    logic       ext, rel, valid, ovf, err;
    logic       ack = 1'b0;

    ps2k_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .ps2kCk(ps2kCk), .ps2kD(ps2kD),
        .code(code), .ext(ext), .rel(rel), .valid(valid), .ack(ack),
        .ovf(ovf), .err(err)
    );

    always #5 clock = ~clock;

`ifdef PS2K_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    int         vectors = 0;
    int         miscompares = 0;
    int         errCnt = 0, ovfCnt = 0, errExp = 0, ovfExp = 0;
    int         lat = 0;
    bit         ackEn = 1'b0;
    bit         mExt = 1'b0, mRel = 1'b0;
    logic [9:0] expQ [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-level model: prefixes latch flags, other bytes become events, bad frames clear flags.
    task automatic modelFrame(input logic [7:0] b, input bit good);
        if (!good) begin
            errExp++;
            mExt = 1'b0;
            mRel = 1'b0;
        end else if (b == 8'hE0) begin
            mExt = 1'b1;
        end else if (b == 8'hF0) begin
            mRel = 1'b1;
        end else begin
            if (expQ.size() >= CAP) ovfExp++;
            else expQ.push_back({mExt, mRel, b});
            mExt = 1'b0;
            mRel = 1'b0;
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            ack = 1'b0;
        end else begin
            if (err) errCnt++;
            if (ovf) ovfCnt++;
            if (valid) begin
                vectors++;
                if (expQ.size() == 0) begin
                    miscompares++;
                    $display("FAIL event: valid with code=%0h ext=%0b rel=%0b but model holds none", code, ext, rel);
                end else if ({ext, rel, code} !== expQ[0]) begin
                    miscompares++;
                    $display("FAIL event: got %0h expected %0h", {ext, rel, code}, expQ[0]);
                end
            end
            ack = 1'b0;
            if (ackEn && valid && $urandom_range(0, 1) == 0) begin
                ack = 1'b1;
                if (expQ.size() != 0) void'(expQ.pop_front());
            end
        end
    end

    task automatic sendFrame(input logic [7:0] b, input bit badPar, input bit badStop, input bit glitch);
        logic [10:0] bits;
        bits = {~badStop, (~^b) ^ badPar, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            @(negedge clock);
            ps2kD = bits[i];
            repeat (HALF / 2) @(negedge clock);
            ps2kCk = 1'b0;
            if (i == 10) begin
                modelFrame(b, !badPar && !badStop);
                lat = 0;
                for (int k = 1; k <= 8; k++) begin
                    @(posedge clock);
                    #1;
                    if (valid && lat == 0) lat = k;
                end
                repeat (HALF - 8) @(negedge clock);
            end else begin
                repeat (HALF) @(negedge clock);
            end
            ps2kCk = 1'b1;
            if (glitch && i > 0 && i < 10) begin
                repeat (8) @(negedge clock);
                ps2kCk = 1'b0;
                repeat (FILTER - 1) @(negedge clock);
                ps2kCk = 1'b1;
                repeat (HALF - 8 - FILTER + 1) @(negedge clock);
            end else begin
                repeat (HALF) @(negedge clock);
            end
        end
        @(negedge clock);
        ps2kD = 1'b1;
    endtask

    // Start bit plus nData data bits; optionally the last falling edge is held low into a timeout.
    task automatic partialFrame(input int nData, input bit hold);
        for (int i = 0; i <= nData; i++) begin
            @(negedge clock);
            ps2kD = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            repeat (HALF / 2) @(negedge clock);
            ps2kCk = 1'b0;
            if (hold && i == nData) begin
                errExp++;
                mExt = 1'b0;
                mRel = 1'b0;
                repeat (TIMEOUT + 20) @(negedge clock);
            end else begin
                repeat (HALF) @(negedge clock);
            end
            ps2kCk = 1'b1;
            repeat (HALF) @(negedge clock);
        end
        ps2kD = 1'b1;
    endtask

    task automatic endCheck();
        chk("errCount", errCnt, errExp);
        chk("ovfCount", ovfCnt, ovfExp);
        chk("validVsModel", 32'(valid), 32'(expQ.size() != 0));
    endtask

    task automatic drain();
        ackEn = 1'b1;
        repeat (30) @(negedge clock);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e0, o0, r;
        logic [7:0] b;
        bit bp, bs;

        repeat (3) @(negedge clock);
        chk("resetCode", 32'(code), 32'h0);
        chk("resetExt", 32'(ext), 32'h0);
        chk("resetRel", 32'(rel), 32'h0);
        chk("resetValid", 32'(valid), 32'h0);
        chk("resetOvf", 32'(ovf), 32'h0);
        chk("resetErr", 32'(err), 32'h0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        sendFrame(8'h1C, 0, 0, 0);
        chk("latency", lat, FILTER + 2);
        chk("firstCode", 32'(code), 32'h1C);
        chk("firstExt", 32'(ext), 32'h0);
        chk("firstRel", 32'(rel), 32'h0);
        chk("firstValid", 32'(valid), 32'h1);
        drain();
        chk("ackClears", 32'(valid), 32'h0);
        endCheck();

        ackEn = 1'b0;
        sendFrame(8'hE0, 0, 0, 0);
        sendFrame(8'hF0, 0, 0, 0);
        sendFrame(8'h75, 0, 0, 0);
        chk("prefCode", 32'(code), 32'h75);
        chk("prefExt", 32'(ext), 32'h1);
        chk("prefRel", 32'(rel), 32'h1);
        endCheck();
        drain();
        ackEn = 1'b0;
        sendFrame(8'h1C, 0, 0, 0);
        chk("postPrefExt", 32'(ext), 32'h0);
        chk("postPrefRel", 32'(rel), 32'h0);
        drain();
        endCheck();

        e0 = errCnt;
        sendFrame(8'h1C, 1, 0, 0);
        chk("parityErr", errCnt - e0, 1);
        chk("parityNoEvent", 32'(valid), 32'h0);
        ackEn = 1'b0;
        sendFrame(8'hE0, 0, 1, 0);
        sendFrame(8'h75, 0, 0, 0);
        chk("badStopExtCleared", 32'(ext), 32'h0);
        chk("badStopCode", 32'(code), 32'h75);
        endCheck();
        drain();

        sendFrame(8'hE0, 0, 0, 0);
        e0 = errCnt;
        partialFrame(4, 1);
        chk("timeoutErr", errCnt - e0, 1);
        ackEn = 1'b0;
        sendFrame(8'h29, 0, 0, 0);
        chk("timeoutNextCode", 32'(code), 32'h29);
        chk("timeoutExtCleared", 32'(ext), 32'h0);
        endCheck();
        drain();

        sendFrame(8'hA5, 0, 0, 1);
        sendFrame(8'h3C, 0, 0, 1);
        endCheck();

        e0 = errCnt;
        partialFrame(3, 0);
        @(negedge clock);
        reset = 1'b1;
        expQ.delete();
        mExt = 1'b0;
        mRel = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        chk("resetMidFrameNoErr", errCnt - e0, 0);
        sendFrame(8'h5A, 0, 0, 0);
        endCheck();

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 99);
            if (r < 15) b = 8'hE0;
            else if (r < 27) b = 8'hF0;
            else b = 8'($urandom_range(0, 255));
            bp = ($urandom_range(0, 99) < 8);
            bs = !bp && ($urandom_range(0, 99) < 5);
            sendFrame(b, bp, bs, $urandom_range(0, 99) < 30);
            repeat ($urandom_range(1, 10)) @(negedge clock);
            endCheck();
        end

        ackEn = 1'b0;
        o0 = ovfCnt;
        for (int n = 0; n <= CAP; n++) sendFrame(8'h10 + 8'(n), 0, 0, 0);
        chk("ovfOnce", ovfCnt - o0, 1);
        chk("ovfHeldCode", 32'(code), 32'h10);
        endCheck();
        drain();
        endCheck();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
